// File: rtl/imem_port_arbiter.sv
// ---------------------------------------------------------------------------
// imem_port_arbiter
//
// Purpose:
//   Shares one combinational instruction-ROM read port between two
//   requesters. Each cycle at most one request is granted. The ROM word for
//   the granted address is captured into that requester's one-entry
//   response slot on the same edge. Misaligned or out-of-range addresses
//   produce an error response instead of ROM data.
//
// Parameters:
//   ROM_SIZE   - ROM size in bytes; addresses >= ROM_SIZE are errors.
//   FIXED_PRIO - 0: round-robin on ties, 1: requester 0 always wins ties.
//
// Ports:
//   clk, rst                  - single clock, synchronous active-high reset
//   mN_req_valid/ready/addr   - request channel of requester N (N = 0, 1)
//   mN_rsp_valid/ready        - response channel handshake of requester N
//   mN_rsp_data, mN_rsp_err   - response payload of requester N
//   rom_addr, rom_rdata       - shared ROM port (read data valid same cycle)
//
// Handshake semantics (all channels):
//   A transfer happens on a rising edge where valid and ready are both high.
//   A producer holds valid and payload stable until the transfer happens.
//   mN_req_ready depends on mN_req_valid and the slot state, never on a
//   later-cycle event. mN_rsp_ready is ignored while mN_rsp_valid is low.
// ---------------------------------------------------------------------------
module imem_port_arbiter #(
    parameter int unsigned ROM_SIZE   = 4096,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req_valid,
    input  logic [31:0] m0_req_addr,
    output logic        m0_req_ready,
    output logic        m0_rsp_valid,
    input  logic        m0_rsp_ready,
    output logic [31:0] m0_rsp_data,
    output logic        m0_rsp_err,

    input  logic        m1_req_valid,
    input  logic [31:0] m1_req_addr,
    output logic        m1_req_ready,
    output logic        m1_rsp_valid,
    input  logic        m1_rsp_ready,
    output logic [31:0] m1_rsp_data,
    output logic        m1_rsp_err,

    output logic [31:0] rom_addr,
    input  logic [31:0] rom_rdata
);

    // -----------------------------------------------------------------------
    // Per-requester vectors, so the slot logic below is written once.
    // -----------------------------------------------------------------------
    logic [1:0]  req_valid_v;
    logic [1:0]  rsp_ready_v;

    // Response slot state.
    logic [1:0]  rsp_valid_q;
    logic [31:0] rsp_data_q [2];
    logic [1:0]  rsp_err_q;

    // Index of the requester that won the most recent accepted transfer.
    // Reset to 1 so that requester 0 wins the first round-robin tie.
    logic        last_grant_q;

    logic [1:0]  slot_free;
    logic [1:0]  eligible;
    logic [1:0]  grant;
    logic        addr_err;
    logic [31:0] load_data;

    assign req_valid_v = {m1_req_valid, m0_req_valid};
    assign rsp_ready_v = {m1_rsp_ready, m0_rsp_ready};

    // -----------------------------------------------------------------------
    // Eligibility and grant.
    // A slot is free when it is empty or its content is consumed this cycle;
    // that lets a requester sustain one transfer per cycle with the slot
    // reloading on the same edge it is drained.
    // -----------------------------------------------------------------------
    always_comb begin
        slot_free = ~rsp_valid_q | rsp_ready_v;
        eligible  = req_valid_v & slot_free;
        grant     = 2'b00;
        if (!rst) begin
            unique case (eligible)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11: begin
                    if (FIXED_PRIO) begin
                        grant = 2'b01;
                    end else begin
                        // Tie: the requester that did not win last time wins.
                        grant = last_grant_q ? 2'b01 : 2'b10;
                    end
                end
                default: grant = 2'b00;
            endcase
        end
    end

    assign m0_req_ready = grant[0];
    assign m1_req_ready = grant[1];

    // With no grant the ROM port still shows requester 0's address; the
    // read result is simply not captured.
    assign rom_addr = grant[1] ? m1_req_addr : m0_req_addr;

    // -----------------------------------------------------------------------
    // Result of the current ROM access. Misaligned or out-of-range addresses
    // return zero data with the error flag, regardless of what the ROM
    // drives for that address.
    // -----------------------------------------------------------------------
    always_comb begin
        addr_err  = (rom_addr[1:0] != 2'b00) || (rom_addr >= 32'(ROM_SIZE));
        load_data = addr_err ? 32'h0000_0000 : rom_rdata;
    end

    // -----------------------------------------------------------------------
    // Response slots and arbitration history.
    // A granted requester always has a free slot, so a load on the grant
    // edge never overwrites an unconsumed response. Consumption without a new
    // grant only clears valid; data and error keep their last values.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q   <= 2'b00;
            rsp_err_q     <= 2'b00;
            rsp_data_q[0] <= 32'h0000_0000;
            rsp_data_q[1] <= 32'h0000_0000;
            last_grant_q  <= 1'b1;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (grant[n]) begin
                    rsp_valid_q[n] <= 1'b1;
                    rsp_data_q[n]  <= load_data;
                    rsp_err_q[n]   <= addr_err;
                end else if (rsp_ready_v[n]) begin
                    rsp_valid_q[n] <= 1'b0;
                end
            end
            if (|grant) begin
                last_grant_q <= grant[1];
            end
        end
    end

    assign m0_rsp_valid = rsp_valid_q[0];
    assign m0_rsp_data  = rsp_data_q[0];
    assign m0_rsp_err   = rsp_err_q[0];
    assign m1_rsp_valid = rsp_valid_q[1];
    assign m1_rsp_data  = rsp_data_q[1];
    assign m1_rsp_err   = rsp_err_q[1];

endmodule

// File: tb/tb_imem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_port_arbiter
//
// Two arbiter instances: index 0 is round-robin, index 1 is fixed priority.
// Each has its own byte-addressed ROM model (byte i = i[7:0] ^ 8'hA5,
// assembled little-endian into a word). A reference model per instance
// predicts grants, ROM address and slot contents from the arbitration rules;
// it is checked on every falling edge. Per-slot expected queues check that
// each consumed response matches the request that produced it, and a grant
// log checks the literal grant sequences of the directed scenarios.
// ---------------------------------------------------------------------------
module tb_imem_port_arbiter;

    localparam int unsigned ROM_SIZE = 4096;

    // -----------------------------------------------------------------------
    // Clock
    // -----------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // DUT signals, indexed [instance][requester]
    // -----------------------------------------------------------------------
    logic        rst       [2];
    logic        req_valid [2][2];
    logic [31:0] req_addr  [2][2];
    logic        req_ready [2][2];
    logic        rsp_valid [2][2];
    logic        rsp_ready [2][2];
    logic [31:0] rsp_data  [2][2];
    logic        rsp_err   [2][2];
    logic [31:0] rom_addr  [2];
    logic [31:0] rom_rdata [2];

    int vectors    = 0;
    int miscompares = 0;

    // -----------------------------------------------------------------------
    // ROM model
    // -----------------------------------------------------------------------
    function automatic logic [7:0] rom_byte(input logic [31:0] a);
        rom_byte = a[7:0] ^ 8'hA5;
    endfunction

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        rom_word = {rom_byte(w + 32'd3), rom_byte(w + 32'd2),
                    rom_byte(w + 32'd1), rom_byte(w)};
    endfunction

    assign rom_rdata[0] = rom_word(rom_addr[0]);
    assign rom_rdata[1] = rom_word(rom_addr[1]);

    imem_port_arbiter #(.ROM_SIZE(ROM_SIZE), .FIXED_PRIO(1'b0)) dut_rr (
        .clk          (clk),
        .rst          (rst[0]),
        .m0_req_valid (req_valid[0][0]),
        .m0_req_addr  (req_addr[0][0]),
        .m0_req_ready (req_ready[0][0]),
        .m0_rsp_valid (rsp_valid[0][0]),
        .m0_rsp_ready (rsp_ready[0][0]),
        .m0_rsp_data  (rsp_data[0][0]),
        .m0_rsp_err   (rsp_err[0][0]),
        .m1_req_valid (req_valid[0][1]),
        .m1_req_addr  (req_addr[0][1]),
        .m1_req_ready (req_ready[0][1]),
        .m1_rsp_valid (rsp_valid[0][1]),
        .m1_rsp_ready (rsp_ready[0][1]),
        .m1_rsp_data  (rsp_data[0][1]),
        .m1_rsp_err   (rsp_err[0][1]),
        .rom_addr     (rom_addr[0]),
        .rom_rdata    (rom_rdata[0])
    );

    imem_port_arbiter #(.ROM_SIZE(ROM_SIZE), .FIXED_PRIO(1'b1)) dut_fp (
        .clk          (clk),
        .rst          (rst[1]),
        .m0_req_valid (req_valid[1][0]),
        .m0_req_addr  (req_addr[1][0]),
        .m0_req_ready (req_ready[1][0]),
        .m0_rsp_valid (rsp_valid[1][0]),
        .m0_rsp_ready (rsp_ready[1][0]),
        .m0_rsp_data  (rsp_data[1][0]),
        .m0_rsp_err   (rsp_err[1][0]),
        .m1_req_valid (req_valid[1][1]),
        .m1_req_addr  (req_addr[1][1]),
        .m1_req_ready (req_ready[1][1]),
        .m1_rsp_valid (rsp_valid[1][1]),
        .m1_rsp_ready (rsp_ready[1][1]),
        .m1_rsp_data  (rsp_data[1][1]),
        .m1_rsp_err   (rsp_err[1][1]),
        .rom_addr     (rom_addr[1]),
        .rom_rdata    (rom_rdata[1])
    );

    // -----------------------------------------------------------------------
    // Comparison helper
    // -----------------------------------------------------------------------
    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // -----------------------------------------------------------------------
    // Reference model and scoreboard
    // -----------------------------------------------------------------------
    bit          m_valid [2][2];
    logic [31:0] m_data  [2][2];
    bit          m_err   [2][2];
    int          m_last  [2];
    logic [32:0] exp_q   [4][$];   // {err, data}, index = inst*2 + requester
    bit          acc     [2][2];   // DUT handshake seen at the last falling edge
    int          glog0[$];         // grant log, round-robin instance
    int          glog1[$];         // grant log, fixed-priority instance

    function automatic logic [32:0] expected_result(input logic [31:0] a);
        bit bad;
        bad = (a[1:0] != 2'b00) || (a >= 32'(ROM_SIZE));
        expected_result = bad ? {1'b1, 32'h0} : {1'b0, rom_word(a)};
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            bit          el [2];
            int          gi;
            logic [32:0] ld;
            logic [32:0] e;

            for (int n = 0; n < 2; n++)
                el[n] = !rst[d] && req_valid[d][n] && (!m_valid[d][n] || rsp_ready[d][n]);

            if (el[0] && el[1]) gi = (d == 1) ? 0 : ((m_last[d] == 0) ? 1 : 0);
            else if (el[0])     gi = 0;
            else if (el[1])     gi = 1;
            else                gi = -1;

            for (int n = 0; n < 2; n++) begin
                chk($sformatf("d%0d_m%0d_req_ready", d, n), 32'(req_ready[d][n]), 32'(gi == n));
                chk($sformatf("d%0d_m%0d_rsp_valid", d, n), 32'(rsp_valid[d][n]), 32'(m_valid[d][n]));
                chk($sformatf("d%0d_m%0d_rsp_data", d, n), rsp_data[d][n], m_data[d][n]);
                chk($sformatf("d%0d_m%0d_rsp_err", d, n), 32'(rsp_err[d][n]), 32'(m_err[d][n]));
                acc[d][n] = req_valid[d][n] && req_ready[d][n];
                if (acc[d][n]) begin
                    if (d == 0) glog0.push_back(n);
                    else        glog1.push_back(n);
                end
            end
            chk($sformatf("d%0d_rom_addr", d), rom_addr[d],
                (gi == 1) ? req_addr[d][1] : req_addr[d][0]);

            // State after the coming rising edge.
            if (rst[d]) begin
                for (int n = 0; n < 2; n++) begin
                    m_valid[d][n] = 1'b0;
                    m_data[d][n]  = 32'h0;
                    m_err[d][n]   = 1'b0;
                    exp_q[d*2+n].delete();
                end
                m_last[d] = 1;
            end else begin
                for (int n = 0; n < 2; n++) begin
                    if (m_valid[d][n] && rsp_ready[d][n]) begin
                        if (exp_q[d*2+n].size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL d%0d_m%0d_sb_order: response consumed, got none expected", d, n);
                        end else begin
                            e = exp_q[d*2+n].pop_front();
                            chk($sformatf("d%0d_m%0d_sb_data", d, n), rsp_data[d][n], e[31:0]);
                            chk($sformatf("d%0d_m%0d_sb_err", d, n), 32'(rsp_err[d][n]), 32'(e[32]));
                        end
                    end
                    if (gi == n) begin
                        ld = expected_result(req_addr[d][n]);
                        m_valid[d][n] = 1'b1;
                        m_data[d][n]  = ld[31:0];
                        m_err[d][n]   = ld[32];
                        exp_q[d*2+n].push_back(ld);
                    end else if (rsp_ready[d][n]) begin
                        m_valid[d][n] = 1'b0;
                    end
                end
                if (gi >= 0) m_last[d] = gi;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Move each requester of instance d to its next word once accepted.
    task automatic advance(input int d);
        for (int n = 0; n < 2; n++)
            if (acc[d][n]) req_addr[d][n] = req_addr[d][n] + 32'd4;
    endtask

    task automatic idle(input int d);
        for (int n = 0; n < 2; n++) begin
            req_valid[d][n] = 1'b0;
            rsp_ready[d][n] = 1'b1;
        end
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        int n0;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            for (int n = 0; n < 2; n++) begin
                req_valid[d][n] = 1'b0;
                req_addr[d][n]  = 32'h0;
                rsp_ready[d][n] = 1'b1;
            end
        end

        // Reset with a request already pending: no ready during reset.
        req_valid[0][0] = 1'b1;
        req_addr[0][0]  = 32'h8;
        step();
        step();
        chk("rst_m0_rsp_valid", 32'(rsp_valid[0][0]), 32'h0);
        chk("rst_m0_rsp_data", rsp_data[0][0], 32'h0);
        chk("rst_m1_rsp_err", 32'(rsp_err[0][1]), 32'h0);

        // Single read of word 2.
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        glog0.delete();
        step();
        req_valid[0][0] = 1'b0;
        chk("single_accepts", 32'(glog0.size()), 32'd1);
        chk("single_rsp_valid", 32'(rsp_valid[0][0]), 32'h1);
        chk("single_rsp_data", rsp_data[0][0], 32'hAEAF_ACAD);
        chk("single_rsp_err", 32'(rsp_err[0][0]), 32'h0);
        step();
        chk("consumed_rsp_valid", 32'(rsp_valid[0][0]), 32'h0);
        chk("consumed_data_kept", rsp_data[0][0], 32'hAEAF_ACAD);

        // Round-robin tie from reset.
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        glog0.delete();
        req_valid[0][0] = 1'b1;
        req_addr[0][0]  = 32'h20;
        req_valid[0][1] = 1'b1;
        req_addr[0][1]  = 32'h40;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 0) chk("rr_first_data", rsp_data[0][0], 32'h8687_8485);
            advance(0);
        end
        idle(0);
        chk("rr_grant_count", 32'(glog0.size()), 32'd6);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr_grant_%0d", i), 32'(glog0[i]), 32'(i % 2));
        step();

        // Error responses and the last in-range word.
        req_valid[0][0] = 1'b1;
        req_addr[0][0]  = 32'h6;
        step();
        req_valid[0][0] = 1'b0;
        chk("misaligned_err", 32'(rsp_err[0][0]), 32'h1);
        chk("misaligned_data", rsp_data[0][0], 32'h0);
        req_valid[0][1] = 1'b1;
        req_addr[0][1]  = 32'h1000;
        step();
        chk("range_err", 32'(rsp_err[0][1]), 32'h1);
        chk("range_data", rsp_data[0][1], 32'h0);
        req_addr[0][1]  = 32'hFFC;
        step();
        req_valid[0][1] = 1'b0;
        chk("last_word_err", 32'(rsp_err[0][1]), 32'h0);
        chk("last_word_data", rsp_data[0][1], 32'h5A5B_5859);
        step();

        // Backpressure on requester 1 while requester 0 streams.
        rsp_ready[0][1] = 1'b0;
        req_valid[0][1] = 1'b1;
        req_addr[0][1]  = 32'h10;
        step();
        req_addr[0][1]  = 32'h14;
        req_valid[0][0] = 1'b1;
        req_addr[0][0]  = 32'h100;
        n0 = glog0.size();
        for (int i = 0; i < 4; i++) begin
            step();
            advance(0);
            chk("bp_m1_rsp_valid", 32'(rsp_valid[0][1]), 32'h1);
            chk("bp_m1_rsp_data", rsp_data[0][1], 32'hB6B7_B4B5);
        end
        chk("bp_m0_grants", 32'(glog0.size() - n0), 32'd4);
        for (int i = n0; i < glog0.size(); i++)
            chk("bp_grant_is_m0", 32'(glog0[i]), 32'd0);
        rsp_ready[0][1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            advance(0);
        end
        idle(0);
        step();
        step();

        // Reset while a response is held.
        rsp_ready[0][0] = 1'b0;
        req_valid[0][0] = 1'b1;
        req_addr[0][0]  = 32'h30;
        step();
        req_valid[0][0] = 1'b0;
        step();
        chk("held_before_rst", 32'(rsp_valid[0][0]), 32'h1);
        rst[0] = 1'b1;
        req_valid[0][0] = 1'b1;
        req_addr[0][0]  = 32'h34;
        step();
        rst[0] = 1'b0;
        chk("rst_mid_valid", 32'(rsp_valid[0][0]), 32'h0);
        chk("rst_mid_data", rsp_data[0][0], 32'h0);
        glog0.delete();
        rsp_ready[0][0] = 1'b1;
        req_addr[0][0]  = 32'h50;
        req_valid[0][1] = 1'b1;
        req_addr[0][1]  = 32'h60;
        step();
        chk("rst_tie_count", 32'(glog0.size()), 32'd1);
        chk("rst_tie_winner", 32'(glog0[0]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            advance(0);
            step();
        end
        idle(0);
        step();

        // Fixed priority instance.
        glog1.delete();
        req_valid[1][0] = 1'b1;
        req_addr[1][0]  = 32'h0;
        req_valid[1][1] = 1'b1;
        req_addr[1][1]  = 32'h80;
        for (int i = 0; i < 4; i++) begin
            step();
            advance(1);
        end
        chk("fp_grant_count", 32'(glog1.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("fp_grant_%0d", i), 32'(glog1[i]), 32'd0);
        req_valid[1][0] = 1'b0;
        step();
        chk("fp_m1_after", 32'(glog1[glog1.size()-1]), 32'd1);
        chk("fp_m1_data", rsp_data[1][1], 32'h2627_2425);
        idle(1);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
